// File: rtl/vec_norm_seq.sv
// Sequential vector normalizer: sum of squares, bit-serial square root, then
// per-channel bit-serial division by the norm, all on one iterative datapath.
module vec_norm_seq #(
  parameter int unsigned DATAWIDTH = 16,
  parameter int unsigned FRAC      = 8,
  parameter int unsigned NUM_CH    = 4,
  localparam int unsigned SSW = 2 * DATAWIDTH + $clog2(NUM_CH),
  localparam int unsigned NW  = (SSW + 1) / 2,
  localparam int unsigned QW  = FRAC + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_valid,
  output logic                          i_ready,
  input  logic                          i_mode,
  input  logic [NUM_CH*DATAWIDTH-1:0]   i_data,
  output logic                          o_valid,
  input  logic                          o_ready,
  output logic [NW-1:0]                 o_norm,
  output logic [NUM_CH*QW-1:0]          o_data,
  output logic                          o_zero
);

  localparam int unsigned DW  = DATAWIDTH;
  localparam int unsigned XW  = NUM_CH * DW;
  localparam int unsigned OW  = NUM_CH * QW;
  localparam int unsigned RW  = NW + 2;
  localparam int unsigned SW2 = 2 * NW;
  localparam int unsigned CW  = $clog2(NW + NUM_CH + QW + 1);

  typedef enum logic [2:0] {IDLE, SUMSQ, SQRT, DIV, DONE} state_t;

  state_t          state;
  logic            rdy;
  logic [XW-1:0]   x;
  logic            mode;
  logic [SSW-1:0]  acc;
  logic [SW2-1:0]  ss;
  logic [NW-1:0]   rem_s;
  logic [NW-1:0]   root;
  logic [NW-1:0]   norm;
  logic [NW-1:0]   d_rem;
  logic [QW-2:0]   q_cur;
  logic [OW-1:0]   qv;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   ch;

  logic [DW-1:0]   cur;
  logic [2*DW-1:0] sq;
  logic [SSW-1:0]  acc_nx;
  logic [RW-1:0]   rem_sh;
  logic [RW-1:0]   trial;
  logic            sq_ge;
  logic [RW-1:0]   rem_nx;
  logic [NW-1:0]   root_nx;
  logic [NW-1:0]   d_base;
  logic            d_in;
  logic [NW:0]     d_sh;
  logic            d_ge;
  logic [NW-1:0]   d_rem_nx;
  logic [QW-1:0]   q_nx;
  logic [OW-1:0]   q_all;

  assign i_ready = rdy;

  // Current channel is always in the low slot; x rotates one channel per step.
  always_comb begin
    cur    = x[DW-1:0];
    sq     = {{DW{1'b0}}, cur} * {{DW{1'b0}}, cur};
    acc_nx = acc + SSW'(sq);
  end

  // One restoring square-root step: bring down two radicand bits, try 4*root+1.
  always_comb begin
    rem_sh  = {rem_s, ss[SW2-1 -: 2]};
    trial   = {root, 2'b01};
    sq_ge   = (rem_sh >= trial);
    rem_nx  = sq_ge ? (rem_sh - trial) : rem_sh;
    root_nx = {root[NW-2:0], sq_ge};
  end

  // One restoring divide step on x*2^FRAC; the first step preloads x>>1 (< norm).
  always_comb begin
    d_base   = (cnt == '0) ? NW'(cur >> 1) : d_rem;
    d_in     = (cnt == '0) ? cur[0] : 1'b0;
    d_sh     = {d_base, d_in};
    d_ge     = (d_sh >= {1'b0, norm});
    d_rem_nx = d_ge ? NW'(d_sh - {1'b0, norm}) : NW'(d_sh);
    q_nx     = {q_cur, d_ge};
    q_all    = {q_nx, qv[OW-1:QW]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      rdy     <= 1'b0;
      x       <= '0;
      mode    <= 1'b0;
      acc     <= '0;
      ss      <= '0;
      rem_s   <= '0;
      root    <= '0;
      norm    <= '0;
      d_rem   <= '0;
      q_cur   <= '0;
      qv      <= '0;
      cnt     <= '0;
      ch      <= '0;
      o_valid <= 1'b0;
      o_norm  <= '0;
      o_data  <= '0;
      o_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid && rdy) begin
            x     <= i_data;
            mode  <= i_mode;
            acc   <= '0;
            cnt   <= '0;
            rdy   <= 1'b0;
            state <= SUMSQ;
          end else begin
            rdy <= 1'b1;
          end
        end
        SUMSQ: begin
          acc <= acc_nx;
          x   <= {x[DW-1:0], x[XW-1:DW]};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(NUM_CH - 1)) begin
            cnt <= '0;
            if (acc_nx == '0) begin
              state   <= DONE;
              o_valid <= 1'b1;
              o_norm  <= '0;
              o_data  <= '0;
              o_zero  <= 1'b1;
            end else begin
              ss    <= SW2'(acc_nx);
              rem_s <= '0;
              root  <= '0;
              state <= SQRT;
            end
          end
        end
        SQRT: begin
          ss    <= {ss[SW2-3:0], 2'b00};
          rem_s <= NW'(rem_nx);
          root  <= root_nx;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(NW - 1)) begin
            cnt  <= '0;
            norm <= root_nx;
            if (mode) begin
              state   <= DONE;
              o_valid <= 1'b1;
              o_norm  <= root_nx;
              o_data  <= '0;
              o_zero  <= 1'b0;
            end else begin
              ch    <= '0;
              state <= DIV;
            end
          end
        end
        DIV: begin
          d_rem <= d_rem_nx;
          q_cur <= q_nx[QW-2:0];
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(QW - 1)) begin
            cnt <= '0;
            x   <= {x[DW-1:0], x[XW-1:DW]};
            qv  <= q_all;
            ch  <= ch + CW'(1);
            if (ch == CW'(NUM_CH - 1)) begin
              state   <= DONE;
              o_valid <= 1'b1;
              o_norm  <= norm;
              o_data  <= q_all;
              o_zero  <= 1'b0;
            end
          end
        end
        DONE: begin
          if (o_ready) begin
            o_valid <= 1'b0;
            rdy     <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_norm_seq.sv
// Directed bench for vec_norm_seq at default parameters with hand-computed results.
module tb_vec_norm_seq;

  localparam int unsigned NW = 17;
  localparam int unsigned QW = 9;
  localparam int unsigned XW = 64;

  logic          clk;
  logic          rst;
  logic          i_valid;
  logic          i_ready;
  logic          i_mode;
  logic [XW-1:0] i_data;
  logic          o_valid;
  logic          o_ready;
  logic [NW-1:0] o_norm;
  logic [4*QW-1:0] o_data;
  logic          o_zero;

  int total = 0;
  int bad   = 0;

  vec_norm_seq dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_mode(i_mode),
    .i_data(i_data), .o_valid(o_valid), .o_ready(o_ready), .o_norm(o_norm),
    .o_data(o_data), .o_zero(o_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] vec(input logic [15:0] c0, input logic [15:0] c1,
                                      input logic [15:0] c2, input logic [15:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  function automatic logic [63:0] pk(input logic [8:0] q0, input logic [8:0] q1,
                                     input logic [8:0] q2, input logic [8:0] q3);
    return {28'h0, q3, q2, q1, q0};
  endfunction

  // Accept one vector and count edges until o_valid (0 on timeout).
  task automatic send(input logic [63:0] d, input logic m, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!i_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    i_data  = d;
    i_mode  = m;
    i_valid = 1'b1;
    @(posedge clk);
    #1 i_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      #1;
      if (o_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic res(input string tag, input int lat, input int exp_lat,
                     input logic [63:0] en, input logic [63:0] ed, input logic ez);
    chk({tag, ".lat"},   64'(lat), 64'(exp_lat));
    chk({tag, ".norm"},  64'(o_norm), en);
    chk({tag, ".data"},  64'(o_data), ed);
    chk({tag, ".zero"},  64'(o_zero), 64'(ez));
  endtask

  task automatic hs(input string tag);
    @(posedge clk);
    #1;
    chk({tag, ".vdrop"}, 64'(o_valid), 64'd0);
    chk({tag, ".irdy"},  64'(i_ready), 64'd1);
  endtask

  initial begin
    int lat;
    logic seen;
    rst = 1'b0; i_valid = 1'b0; i_mode = 1'b0; i_data = '0; o_ready = 1'b1;
    #12;
    chk("rst.irdy",  64'(i_ready), 64'd0);
    chk("rst.valid", 64'(o_valid), 64'd0);
    chk("rst.norm",  64'(o_norm),  64'd0);
    chk("rst.data",  64'(o_data),  64'd0);
    chk("rst.zero",  64'(o_zero),  64'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 chk("rel.irdy", 64'(i_ready), 64'd1);

    send(vec(16'h0300, 16'h0400, 16'h0, 16'h0), 1'b0, lat);
    res("v34", lat, 57, 64'h00500, pk(9'h099, 9'h0CC, 9'h0, 9'h0), 1'b0);
    hs("v34");

    send(vec(16'h0100, 16'h0100, 16'h0100, 16'h0100), 1'b0, lat);
    res("ones", lat, 57, 64'h00200, pk(9'h080, 9'h080, 9'h080, 9'h080), 1'b0);
    hs("ones");

    send(vec(16'h0100, 16'h0100, 16'h0100, 16'h0100), 1'b1, lat);
    res("ones_m1", lat, 21, 64'h00200, 64'h0, 1'b0);
    hs("ones_m1");

    send(vec(16'hFFFF, 16'h0, 16'h0, 16'h0), 1'b0, lat);
    res("max0", lat, 57, 64'h0FFFF, pk(9'h100, 9'h0, 9'h0, 9'h0), 1'b0);
    hs("max0");

    send(vec(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), 1'b0, lat);
    res("maxall", lat, 57, 64'h1FFFE, pk(9'h080, 9'h080, 9'h080, 9'h080), 1'b0);
    hs("maxall");

    send(64'h0, 1'b0, lat);
    res("zero", lat, 4, 64'h0, 64'h0, 1'b1);
    hs("zero");

    // Backpressure: result must hold while a competing vector is offered.
    o_ready = 1'b0;
    send(vec(16'h0300, 16'h0400, 16'h0, 16'h0), 1'b0, lat);
    res("bp", lat, 57, 64'h00500, pk(9'h099, 9'h0CC, 9'h0, 9'h0), 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      i_valid = 1'b1;
      i_data  = vec(16'h0100, 16'h0100, 16'h0100, 16'h0100);
      i_mode  = 1'b0;
      @(posedge clk);
      #1;
      chk("bp.valid", 64'(o_valid), 64'd1);
      chk("bp.norm",  64'(o_norm),  64'h00500);
      chk("bp.data",  64'(o_data),  pk(9'h099, 9'h0CC, 9'h0, 9'h0));
      chk("bp.irdy",  64'(i_ready), 64'd0);
    end
    @(negedge clk);
    i_valid = 1'b0;
    o_ready = 1'b1;
    hs("bp");
    send(vec(16'h0100, 16'h0100, 16'h0100, 16'h0100), 1'b0, lat);
    res("bp2", lat, 57, 64'h00200, pk(9'h080, 9'h080, 9'h080, 9'h080), 1'b0);
    hs("bp2");

    // Reset pulse while the divider is running.
    @(negedge clk);
    i_data  = vec(16'h0300, 16'h0400, 16'h0, 16'h0);
    i_mode  = 1'b0;
    i_valid = 1'b1;
    @(posedge clk);
    #1 i_valid = 1'b0;
    repeat (25) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("mrst.valid", 64'(o_valid), 64'd0);
    chk("mrst.norm",  64'(o_norm),  64'd0);
    chk("mrst.data",  64'(o_data),  64'd0);
    chk("mrst.zero",  64'(o_zero),  64'd0);
    chk("mrst.irdy",  64'(i_ready), 64'd0);
    @(negedge clk) rst = 1'b1;
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (o_valid) seen = 1'b1;
    end
    chk("mrst.stale", 64'(seen), 64'd0);
    send(vec(16'h0, 16'h0, 16'h0600, 16'h0800), 1'b0, lat);
    res("post", lat, 57, 64'h00A00, pk(9'h0, 9'h0, 9'h099, 9'h0CC), 1'b0);
    hs("post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
